// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, state encoding and drain-length helper for systolic_seq_ctrl
package systolic_pkg;

    localparam int ARR_N_DEF = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_FEED   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    // Cycles needed for the last injected vector to leave an n x n array.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// rtl/seq_phase_cnt.sv - up-counter with sync clear/enable and terminal-count flag, shared by LOAD_W and DRAIN
module seq_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic [W-1:0] cnt,
    output logic         tc_hit
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign tc_hit = (cnt_q == tc);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - preload/feed/drain sequencer for the systolic array
// Optional FEED stall counter: define SYSTOLIC_SEQ_STALL_CNT_EN.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int ARR_N = ARR_N_DEF,
    parameter int ROW_W = $clog2(ARR_N),
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VEC_W-1:0] num_vec,
    input  logic             act_valid,
    output logic             act_ready,
    output logic             w_load,
    output logic [ROW_W-1:0] w_row,
    output logic             arr_en,
    output logic             busy,
    output logic             done,
    output logic [15:0]      stall_cnt
);

    localparam logic [ROW_W:0] LOAD_TC  = (ROW_W+1)'(ARR_N - 1);
    localparam logic [ROW_W:0] DRAIN_TC = (ROW_W+1)'(drain_len(ARR_N) - 1);

    logic [2:0]       state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [ROW_W:0]   cnt_tc_val;
    logic [ROW_W:0]   phase_cnt;
    logic             unused_cnt_msb;

    seq_phase_cnt #(.W(ROW_W + 1)) u_phase_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc     (cnt_tc_val),
        .cnt    (phase_cnt),
        .tc_hit (cnt_tc)
    );

    assign unused_cnt_msb = phase_cnt[ROW_W];

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        cnt_tc_val = LOAD_TC;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_W;
                    vec_d   = num_vec;
                    cnt_clr = 1'b1;
                end
            end
            ST_LOAD_W: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = (vec_q == '0) ? ST_FIN : ST_FEED;
                end
            end
            ST_FEED: begin
                // vec_q is never 0 here: a zero-length job bypasses FEED.
                if (act_valid) begin
                    vec_d = vec_q - VEC_W'(1);
                    if (vec_q == VEC_W'(1)) begin
                        state_d = ST_DRAIN;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_en     = 1'b1;
                cnt_tc_val = DRAIN_TC;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    assign act_ready = (state_q == ST_FEED);
    assign arr_en    = ((state_q == ST_FEED) && act_valid) || (state_q == ST_DRAIN);
    assign w_load    = (state_q == ST_LOAD_W);
    assign w_row     = w_load ? phase_cnt[ROW_W-1:0] : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);

`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == ST_FEED) && !act_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized self-checking bench for systolic_seq_ctrl against a cycle-count job model
module tb_systolic_seq_ctrl;

    localparam int N     = 8;
    localparam int ROW_W = 3;
    localparam int VEC_W = 8;
    localparam int DRN   = 2 * N - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [VEC_W-1:0] num_vec;
    logic             act_valid;
    logic             act_ready;
    logic             w_load;
    logic [ROW_W-1:0] w_row;
    logic             arr_en;
    logic             busy;
    logic             done;
    logic [15:0]      stall_cnt;

    systolic_seq_ctrl #(.ARR_N(N), .ROW_W(ROW_W), .VEC_W(VEC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_vec   (num_vec),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .w_load    (w_load),
        .w_row     (w_row),
        .arr_en    (arr_en),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Job model: position within a job is the number of cycles since acceptance,
    // phases follow from that count and from how many vectors have transferred.
    bit m_active;
    int m_c, m_v, m_xfer, m_dstart, m_stall;
    int cyc, acc_cyc, done_cyc;
    int n_done, n_xfer, n_ready, n_arr, n_wload;
    bit e_busy, e_done, e_wload, e_arr, e_ready, e_feed;
    int e_row;
    bit pat_q[$];

    function automatic bit model_feeding();
        return m_active && (m_c > N) && (m_xfer < m_v);
    endfunction

    function automatic bit model_fin();
        if (!m_active) return 1'b0;
        if (m_v == 0) return (m_c == N + 1);
        return (m_dstart > 0) && (m_c == m_dstart + DRN);
    endfunction

    task automatic model_expect(input bit av);
        e_busy = m_active; e_done = 0; e_wload = 0; e_arr = 0; e_ready = 0; e_row = 0;
        e_feed = model_feeding();
        if (m_active) begin
            if (m_c <= N) begin
                e_wload = 1; e_row = m_c - 1;
            end else if (e_feed) begin
                e_ready = 1; e_arr = av;
            end else if (model_fin()) begin
                e_done = 1;
            end else begin
                e_arr = 1;
            end
        end
    endtask

    task automatic drive_and_check(input bit st, input int nv, input bit av);
        @(negedge clk);
        start = st; num_vec = nv[VEC_W-1:0]; act_valid = av;
        #1;
        model_expect(av);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("w_load", w_load, e_wload);
        check("w_row", w_row, e_row);
        check("arr_en", arr_en, e_arr);
        check("act_ready", act_ready, e_ready);
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`else
        check("stall_cnt", stall_cnt, 0);
`endif
        if (done === 1'b1) begin n_done++; done_cyc = cyc; end
        if (act_ready === 1'b1 && av) n_xfer++;
        if (act_ready === 1'b1) n_ready++;
        if (arr_en === 1'b1) n_arr++;
        if (w_load === 1'b1) n_wload++;
    endtask

    task automatic step(input bit st, input int nv, input bit av);
        drive_and_check(st, nv, av);
        @(posedge clk);
        if (!m_active) begin
            if (st) begin
                m_active = 1; m_c = 1; m_v = nv; m_xfer = 0; m_dstart = 0; m_stall = 0;
                acc_cyc = cyc;
            end
        end else if (e_done) begin
            m_active = 0;
        end else begin
            if (e_feed) begin
                if (av) begin
                    m_xfer++;
                    if (m_xfer == m_v) m_dstart = m_c + 1;
                end else if (m_stall < 65535) begin
                    m_stall++;
                end
            end
            m_c++;
        end
        cyc++;
    endtask

    task automatic step_rst(input bit av);
        drive_and_check(1'b0, 0, av);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_w_load", w_load, 0);
        check("rst_w_row", w_row, 0);
        check("rst_arr_en", arr_en, 0);
        check("rst_act_ready", act_ready, 0);
        check("rst_stall", stall_cnt, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        m_active = 0; m_stall = 0;
        cyc++;
    endtask

    // mode: 0 = act_valid always 1, 1 = random, 2 = pat_q during FEED
    task automatic run_job(input int v, input int mode, input bit noise, input int rst_drain);
        bit av, st;
        int nv;
        n_done = 0; n_xfer = 0; n_ready = 0; n_arr = 0; n_wload = 0; done_cyc = -1;
        step(1'b1, v, 1'b1);
        for (int b = 0; b < 3000 && m_active; b++) begin
            if (mode == 0) av = 1'b1;
            else if (mode == 2 && model_feeding() && pat_q.size() > 0) av = pat_q.pop_front();
            else av = 1'($urandom_range(0, 1));
            if (rst_drain > 0 && m_dstart > 0 && m_c == m_dstart + rst_drain - 1) begin
                step_rst(av);
                break;
            end
            st = noise && (model_fin() || ($urandom_range(0, 3) == 0));
            nv = noise ? int'($urandom_range(0, 255)) : v;
            step(st, nv, av);
        end
        if (m_active) check("job_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; num_vec = '0; act_valid = 1'b0;
        m_active = 0; m_stall = 0; cyc = 0;
        #1 rst = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_w_load", w_load, 0);
        check("reset_arr_en", arr_en, 0);
        check("reset_act_ready", act_ready, 0);
        check("reset_stall", stall_cnt, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        run_job(4, 0, 1'b0, 0);
        check("t1_latency", done_cyc - acc_cyc, 28);
        check("t1_wload_cycles", n_wload, 8);
        check("t1_ready_cycles", n_ready, 4);
        check("t1_arr_en_cycles", n_arr, 4 + 15);
        check("t1_done_count", n_done, 1);
        step(1'b0, 0, 1'b0);

        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_job(3, 2, 1'b0, 0);
        check("t2_ready_cycles", n_ready, 5);
        check("t2_xfer", n_xfer, 3);
`ifdef SYSTOLIC_SEQ_STALL_CNT_EN
        check("t2_stall", stall_cnt, 2);
`else
        check("t2_stall", stall_cnt, 0);
`endif
        step(1'b0, 0, 1'b1);

        run_job(0, 1, 1'b0, 0);
        check("t3_latency", done_cyc - acc_cyc, 9);
        check("t3_wload_cycles", n_wload, 8);
        check("t3_ready_cycles", n_ready, 0);
        check("t3_arr_en_cycles", n_arr, 0);
        step(1'b0, 0, 1'b0);

        run_job(5, 1, 1'b1, 0);
        check("t4_done_count", n_done, 1);
        check("t4_xfer", n_xfer, 5);
        step(1'b0, 0, 1'b0);

        run_job(6, 0, 1'b0, 5);
        check("t5_no_done", n_done, 0);
        run_job(2, 0, 1'b0, 0);
        check("t5_post_rst_latency", done_cyc - acc_cyc, 8 + 2 + 15 + 1);
        check("t5_post_rst_done", n_done, 1);

        run_job(255, 0, 1'b0, 0);
        check("t6_xfer", n_xfer, 255);
        check("t6_latency", done_cyc - acc_cyc, 279);

        for (int j = 0; j < 6; j++) begin
            int v;
            v = int'($urandom_range(0, 20));
            run_job(v, 1, j[0], 0);
            check("rand_done_count", n_done, 1);
            check("rand_xfer", n_xfer, v);
            repeat (int'($urandom_range(0, 2))) step(1'b0, 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencing controller directly upstream of the systolic array and its enable-gated row/cycle counters.
- On a start pulse, it steps through three phases: weight preload (one row per cycle), activation streaming with a valid/ready handshake, and pipeline drain.
- It produces the array-wide enable that the downstream counters and PEs consume; deasserted enable holds those counters at 0.
- It reports busy/done to the host-side control.

Parameters:
- ARR_N, 8, array dimension (rows = cols); must be a power of 2, range 2..16.
- ROW_W, $clog2(ARR_N), width of row index and phase counter.
- VEC_W, 8, width of the vector-count input.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a job; sampled only in IDLE.
- num_vec  input  VEC_W  number of activation vectors for the job; latched when start is accepted.
- act_valid  input  1  upstream activation vector valid.
- act_ready  output  1  controller accepts the activation vector this cycle.
- w_load  output  1  weight row write strobe to the array.
- w_row  output  ROW_W  weight row index qualified by w_load.
- arr_en  output  1  array/counter enable (shift and accumulate).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at job completion.
- stall_cnt  output  16  FEED-phase stall cycles (see Optional Feature).

Behaviour:
- Reset state: state=IDLE; all outputs 0; latched vec count 0; phase counter 0.
- States: IDLE, LOAD_W, FEED, DRAIN, FIN. Encoding is binary.
- IDLE:
  - start=1 latches num_vec, clears the phase counter and goes to LOAD_W next cycle.
  - start while not IDLE is ignored; there is no queueing.
- LOAD_W:
  - w_load=1 and w_row=phase counter, for ARR_N consecutive cycles (rows 0..ARR_N-1).
  - arr_en=0 and act_ready=0.
  - On row ARR_N-1: if the latched count is 0, go to FIN; otherwise go to FEED.
- FEED:
  - act_ready=1 and arr_en = act_valid.
  - A transfer occurs when act_valid && act_ready, and decrements the remaining-vector count.
  - act_valid=0 stalls: arr_en=0, nothing else changes.
  - The transfer that decrements the count to 0 moves the state to DRAIN and clears the phase counter.
- DRAIN:
  - arr_en=1 and act_ready=0 for exactly 2*ARR_N-1 cycles.
  - The counter is 0..2*ARR_N-2, so it is ROW_W+1 bits wide.
  - After the last drain cycle, go to FIN.
- FIN:
  - done=1 for one cycle, busy still 1.
  - Return to IDLE unconditionally.
  - A start asserted during FIN is ignored.
- Latency (start sampled to done): ARR_N + V + (2*ARR_N-1) + 1 cycles, given no stalls and V>0.
- Latency with V=0: ARR_N+1 cycles.
- Outputs are registered or a pure decode of the state register plus act_valid; there are no combinational paths from start to any output.
- Asynchronous rst mid-job:
  - Immediate return to IDLE, all outputs 0.
  - No done pulse; the partial job is abandoned.
  - A start arriving on the first cycle after rst deasserts is accepted.
- num_vec is not sampled outside IDLE; changes mid-job have no effect.
- Maximum num_vec = 2^VEC_W-1; the count never wraps.

Optional Feature:
- Macro: SYSTOLIC_SEQ_STALL_CNT_EN.
- Defined:
  - stall_cnt counts FEED cycles with act_valid=0.
  - Cleared on start acceptance and on rst; saturates at 16'hFFFF.
  - Holds its value after done until the next start.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is synthesized.

Decomposition:
- Package systolic_pkg holds:
  - ARR_N default;
  - state encoding localparams ST_IDLE=0, ST_LOAD_W=1, ST_FEED=2, ST_DRAIN=3, ST_FIN=4;
  - a function returning the drain length 2*ARR_N-1.
- Sub-module seq_phase_cnt:
  - Synchronous clear and enable, width parameter, terminal-count input and tc output.
  - Instanced once, shared by LOAD_W and DRAIN.
- The FSM and the remaining-vector down-counter live in the top module.

Test Plan:
- Reset then start with num_vec=4, act_valid held 1 -> w_load high 8 cycles with w_row 0..7; act_ready high 4 cycles; arr_en high 4+15 cycles; done at cycle 28 after start; busy low the next cycle.
- num_vec=3, act_valid pattern 1,0,0,1,1 -> FEED lasts 5 cycles; arr_en mirrors act_valid; DRAIN starts after the 3rd transfer; stall_cnt=2 with macro defined, 0 without.
- num_vec=0 -> 8 w_load cycles, no act_ready, no arr_en, done 9 cycles after start.
- start pulsed again during FEED and during FIN, and num_vec changed mid-job -> ignored; exactly one done; vector count is the originally latched value.
- rst asserted during DRAIN cycle 5 -> all outputs 0 immediately; no done; a new start on the first post-reset cycle runs a full job correctly.
- num_vec=255 with act_valid always 1 -> exactly 255 transfers, no wrap; done at cycle 8+255+15+1=279.
